// File: rtl/simt_branch_sequencer_if.sv
// Bundle between the fetch path / core array and the global program sequencer.
// The fetch side (master) presents the decoded instruction and divergence flags;
// the sequencer (slave) returns the fetch address, next PC/SP and array enable.
interface simt_branch_sequencer_if #(
    parameter int NUM_CORES = 16,
    parameter int PC_WIDTH  = 8,
    parameter int SP_WIDTH  = 3
);
    logic                 start;
    logic                 instr_valid;
    logic [2:0]           op;
    logic [PC_WIDTH-1:0]  target;
    logic [NUM_CORES-1:0] diverge;

    logic [PC_WIDTH-1:0]  program_counter;
    logic [PC_WIDTH-1:0]  next_program_counter;
    logic [SP_WIDTH-1:0]  next_stack_pointer;
    logic                 global_enable;
    logic                 busy;
    logic                 halted;
    logic                 fault;

    modport master (
        output start, instr_valid, op, target, diverge,
        input  program_counter, next_program_counter, next_stack_pointer,
        input  global_enable, busy, halted, fault
    );

    modport slave (
        input  start, instr_valid, op, target, diverge,
        output program_counter, next_program_counter, next_stack_pointer,
        output global_enable, busy, halted, fault
    );
endinterface

// File: rtl/simt_branch_sequencer.sv
// Global program sequencer for the lock-step core array. Owns the shared PC
// and return stack, resolves array-wide control flow per fetched instruction
// and folds the per-core diverge flags into the conditional-branch decision.
module simt_branch_sequencer #(
    parameter int NUM_CORES = 16,
    parameter int PC_WIDTH  = 8,
    parameter int SP_WIDTH  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    simt_branch_sequencer_if.slave bus
);
    localparam int DEPTH = 1 << SP_WIDTH;

    localparam logic [2:0] OP_BRZ  = 3'd1;
    localparam logic [2:0] OP_JMP  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_HALT = 3'd5;

    localparam logic [PC_WIDTH-1:0]  PC_ZERO      = {PC_WIDTH{1'b0}};
    localparam logic [PC_WIDTH-1:0]  PC_ONE       = {{(PC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SP_WIDTH-1:0]  SP_ZERO      = {SP_WIDTH{1'b0}};
    localparam logic [SP_WIDTH-1:0]  SP_ONE       = {{(SP_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SP_WIDTH-1:0]  SP_FULL      = {SP_WIDTH{1'b1}};
    localparam logic [NUM_CORES-1:0] ALL_DIVERGED = {NUM_CORES{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [PC_WIDTH-1:0] pc_r;
    logic [PC_WIDTH-1:0] pc_s;
    logic [PC_WIDTH-1:0] pc_inc_s;
    logic [SP_WIDTH-1:0] sp_r;
    logic [SP_WIDTH-1:0] sp_s;
    logic [SP_WIDTH-1:0] sp_dec_s;
    logic                push_s;
    logic                enable_s;
    logic                busy_r;
    logic                halted_r;
    logic                fault_r;

    // Return addresses; contents are don't-care after reset, only SP is reset.
    logic [PC_WIDTH-1:0] stack_r [0:DEPTH-1];

    assign pc_inc_s = pc_r + PC_ONE;
    assign sp_dec_s = sp_r - SP_ONE;

    // Next PC/SP/state decision for the current instruction and control inputs.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        sp_s     = sp_r;
        push_s   = 1'b0;
        enable_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (bus.instr_valid) begin
                    enable_s = 1'b1;
                    case (bus.op)
                        OP_BRZ: begin
                            // Jump only once every core has taken (or already took) the branch.
                            if (bus.diverge == ALL_DIVERGED) begin
                                pc_s = bus.target;
                            end else begin
                                pc_s = pc_inc_s;
                            end
                        end
                        OP_JMP: begin
                            pc_s = bus.target;
                        end
                        OP_CALL: begin
                            // The top slot is never pushed: SP would wrap and lose the frame.
                            if (sp_r == SP_FULL) begin
                                state_s = ST_FAULT;
                            end else begin
                                push_s = 1'b1;
                                sp_s   = sp_r + SP_ONE;
                                pc_s   = bus.target;
                            end
                        end
                        OP_RET: begin
                            if (sp_r == SP_ZERO) begin
                                state_s = ST_FAULT;
                            end else begin
                                sp_s = sp_dec_s;
                                pc_s = stack_r[sp_dec_s];
                            end
                        end
                        OP_HALT: begin
                            state_s = ST_HALTED;
                        end
                        default: begin
                            pc_s = pc_inc_s;
                        end
                    endcase
                end else begin
                    enable_s = 1'b0;
                end
            end
            ST_IDLE, ST_HALTED, ST_FAULT: begin
                if (bus.start) begin
                    state_s = ST_RUN;
                    pc_s    = PC_ZERO;
                    sp_s    = SP_ZERO;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                pc_s    = PC_ZERO;
                sp_s    = SP_ZERO;
            end
        endcase
    end

    // Sequencer state, PC, SP and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            pc_r     <= PC_ZERO;
            sp_r     <= SP_ZERO;
            busy_r   <= 1'b0;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            sp_r     <= sp_s;
            busy_r   <= (state_s == ST_RUN);
            halted_r <= (state_s == ST_HALTED);
            fault_r  <= (state_s == ST_FAULT);
        end
    end

    // Return-stack write; a RET on the following edge reads this entry directly.
    always_ff @(posedge clk) begin
        if (push_s) begin
            stack_r[sp_r] <= pc_inc_s;
        end
    end

    assign bus.program_counter      = pc_r;
    assign bus.next_program_counter = pc_s;
    assign bus.next_stack_pointer   = sp_s;
    assign bus.global_enable        = enable_s;
    assign bus.busy                 = busy_r;
    assign bus.halted               = halted_r;
    assign bus.fault                = fault_r;
endmodule

// File: doc/simt_branch_sequencer.md
# simt_branch_sequencer

Global program sequencer for the lock-step core array. It owns the shared program counter and call-stack pointer, decides the array-wide control flow of each fetched instruction (fall-through, jump, call, return, halt), and combines per-core `diverge` flags into the conditional-branch decision. It drives `global_enable`, `next_program_counter` and `next_stack_pointer` to every core's local control and sits between the instruction fetch path and the core array.

## Interface
- `NUM_CORES`, 16: number of cores; width of `diverge`.
- `PC_WIDTH`, 8: program counter width.
- `SP_WIDTH`, 3: stack pointer width; return stack holds 2^SP_WIDTH entries of PC_WIDTH bits.

- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin or restart execution at address 0.
- `instr_valid` in 1: fetched instruction for `program_counter` is present this cycle.
- `op` in 3: decoded class: 0 ALU/NOP, 1 BRZ (conditional), 2 JMP, 3 CALL, 4 RET, 5 HALT; 6–7 treated as ALU.
- `target` in PC_WIDTH: branch/call target (instruction immediate).
- `diverge` in NUM_CORES: per-core divergence flags, one per core.
- `program_counter` out PC_WIDTH: registered fetch address.
- `next_program_counter` out PC_WIDTH: combinational PC for next cycle.
- `next_stack_pointer` out SP_WIDTH: combinational SP for next cycle.
- `global_enable` out 1: array executes the current instruction.
- `busy` out 1: state is RUN.
- `halted` out 1: state is HALTED.
- `fault` out 1: state is FAULT.

## Operation
- States: IDLE, RUN, HALTED, FAULT. Reset → IDLE, `program_counter`=0, SP=0, stack contents don't-care.
- IDLE: `start` → RUN, PC=0, SP=0.
- HALTED or FAULT: `start` → RUN, PC=0, SP=0. Otherwise hold.
- RUN with `instr_valid`=0: stall. PC, SP held. `global_enable`=0.
- RUN with `instr_valid`=1: `global_enable`=1. Next PC/SP by `op`:
  - ALU: PC+1 (wraps modulo 2^PC_WIDTH), SP unchanged.
  - BRZ: if `&diverge` (every core diverges or is already diverged), jump: PC=`target`. Otherwise PC+1. Diverged cores wait locally and rejoin when `next_program_counter` reaches their target.
  - JMP: PC=`target`.
  - CALL: stack[SP]<=PC+1, SP+1, PC=`target`. If SP==2^SP_WIDTH−1 (full): no push, PC/SP held, → FAULT.
  - RET: SP−1, PC=stack[SP−1]. If SP==0 (empty): PC/SP held, → FAULT.
  - HALT: PC/SP held, → HALTED.
- `next_program_counter`/`next_stack_pointer` equal the current PC/SP whenever no update occurs (IDLE, stall, HALTED, FAULT, HALT, fault cycle). Exceptions: on `start` from a non-RUN state, or from IDLE, they read 0.
- `start` while in RUN is ignored.

## Timing
- One instruction per cycle when `instr_valid` is held high. PC updates on the edge after the cycle in which the instruction is valid.
- `next_*` and `global_enable` are combinational from state, `op`, `target`, `diverge`, `instr_valid`. `program_counter`, SP and state are registered.
- Outputs in reset: `program_counter`=0, `next_program_counter`=0, `next_stack_pointer`=0, `global_enable`=0, `busy`=0, `halted`=0, `fault`=0.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs 0. No pending push or pop survives.
- CALL immediately followed by RET: the RET reads the entry written on the previous edge (stack write and read are on consecutive edges, no bypass needed).
- `fault` and `halted` assert in the cycle after the offending or HALT instruction and stay high until `start` or reset.

## Test plan
- Reset, `start`, then 4 ALU ops with `instr_valid`=1 → PC 0,1,2,3,4. `global_enable`=1 each cycle. Insert `instr_valid`=0 at PC=2 → PC holds at 2, `global_enable`=0.
- BRZ `target`=0x20 with `diverge`=all-ones → next PC 0x20. Same with `diverge`=0x0001 → next PC = PC+1.
- CALL 0x40 at PC=0x05 → PC 0x40, SP 1. Then RET → PC 0x06, SP 0. Back-to-back CALL/RET also correct.
- Seven nested CALLs (SP_WIDTH=3) succeed with SP=7. An eighth CALL → `fault`=1, PC/SP unchanged. RET at SP=0 after restart → `fault`=1.
- HALT at PC=0x10 → `halted`=1, PC stays 0x10. `start` → PC=0, `busy`=1. PC at 0xFF with ALU → wraps to 0x00.
- Assert `rst` low mid-CALL → all outputs 0 asynchronously, state IDLE, SP=0 after release.
